// File: rtl/micro_itlb_if.sv
// Fetch-side request/response and joint-TLB lookup signals of the micro ITLB.
// master drives requests and lookup results; slave is the micro ITLB.
interface micro_itlb_if;
    logic        req_valid;
    logic [31:0] req_vaddr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_miss;
    logic        resp_illegal;
    logic        tlb_req;
    logic [19:0] tlb_vpn;
    logic        tlb_ack;
    logic        tlb_miss;
    logic [19:0] tlb_pfn;
    logic        tlb_v;
    logic        tlb_g;

    modport master (
        output req_valid, req_vaddr,
        input  req_ready,
        input  resp_valid, resp_paddr, resp_miss, resp_illegal,
        input  tlb_req, tlb_vpn,
        output tlb_ack, tlb_miss, tlb_pfn, tlb_v, tlb_g
    );

    modport slave (
        input  req_valid, req_vaddr,
        output req_ready,
        output resp_valid, resp_paddr, resp_miss, resp_illegal,
        output tlb_req, tlb_vpn,
        input  tlb_ack, tlb_miss, tlb_pfn, tlb_v, tlb_g
    );
endinterface

// File: rtl/micro_itlb.sv
// Fully-associative instruction micro TLB in front of the joint TLB.
// Define MICRO_ITLB_STATS_EN to add saturating hit/miss counters.
module micro_itlb #(
    parameter int ENTRIES = 4,
    localparam int PTR_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  asid,
    input  logic        flush,
`ifdef MICRO_ITLB_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    micro_itlb_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [ENTRIES-1:0] r_present;
    logic [19:0]        r_vpn [ENTRIES];
    logic [7:0]         r_asid [ENTRIES];
    logic               r_g [ENTRIES];
    logic [19:0]        r_pfn [ENTRIES];
    logic               r_v [ENTRIES];
    logic [PTR_W-1:0]   r_ptr;
    logic               r_tlb_req;
    logic [19:0]        r_tlb_vpn;
    logic [11:0]        r_off;
    logic               r_kill;
    logic               r_resp_valid;
    logic [31:0]        r_resp_paddr;
    logic               r_resp_miss;
    logic               r_resp_illegal;

    logic               w_hit;
    logic [PTR_W-1:0]   w_hit_idx;
    logic               w_accept;
    logic               w_ack;
    logic               w_fill;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_ack    = (r_state == S_REFILL) && bus.tlb_ack;
    // A flush anywhere in the refill window drops the fill, not the reply
    assign w_fill   = w_ack && !bus.tlb_miss && !flush && !r_kill;

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_paddr   = r_resp_paddr;
    assign bus.resp_miss    = r_resp_miss;
    assign bus.resp_illegal = r_resp_illegal;
    assign bus.tlb_req      = r_tlb_req;
    assign bus.tlb_vpn      = r_tlb_vpn;

    // Associative match; fills only follow misses so at most one hits
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_present[i] &&
                r_vpn[i] == bus.req_vaddr[31:12] &&
                (r_g[i] || r_asid[i] == asid)) begin
                w_hit     = 1'b1;
                w_hit_idx = PTR_W'(i);
            end
        end
    end

    // Valid bits and round-robin victim pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_present <= '0;
            r_ptr     <= '0;
        end else if (flush) begin
            r_present <= '0;
        end else if (w_fill) begin
            r_present[r_ptr] <= 1'b1;
            r_ptr            <= r_ptr + 1'b1;
        end
    end

    // Entry payload, qualified by the valid bits above
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_vpn[r_ptr]  <= r_tlb_vpn;
            r_asid[r_ptr] <= asid;
            r_g[r_ptr]    <= bus.tlb_g;
            r_pfn[r_ptr]  <= bus.tlb_pfn;
            r_v[r_ptr]    <= bus.tlb_v;
        end
    end

    // Control FSM with registered lookup request and response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_tlb_req      <= 1'b0;
            r_tlb_vpn      <= '0;
            r_off          <= '0;
            r_kill         <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_paddr   <= '0;
            r_resp_miss    <= 1'b0;
            r_resp_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (w_accept) begin
                        if (w_hit) begin
                            r_resp_valid   <= 1'b1;
                            r_resp_paddr   <= {r_pfn[w_hit_idx],
                                               bus.req_vaddr[11:0]};
                            r_resp_miss    <= 1'b0;
                            r_resp_illegal <= ~r_v[w_hit_idx];
                        end else begin
                            r_state   <= S_REFILL;
                            r_tlb_req <= 1'b1;
                            r_tlb_vpn <= bus.req_vaddr[31:12];
                            r_off     <= bus.req_vaddr[11:0];
                            r_kill    <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (bus.tlb_ack) begin
                        r_tlb_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                        if (bus.tlb_miss) begin
                            r_resp_paddr   <= '0;
                            r_resp_miss    <= 1'b1;
                            r_resp_illegal <= 1'b0;
                        end else begin
                            r_resp_paddr   <= {bus.tlb_pfn, r_off};
                            r_resp_miss    <= 1'b0;
                            r_resp_illegal <= ~bus.tlb_v;
                        end
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MICRO_ITLB_STATS_EN
    // Saturating hit and refill counters, untouched by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
